bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter PRESCALE, default 12: raw_clk cycles per count tick, legal range 1..65535.
REQ-002 Port raw_clk, input, 1: single clock; all logic is on its rising edge.
REQ-003 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port address, input, 4: byte offset within the block; bits [3:2] select the word and bits [1:0] are ignored.
REQ-005 Port data_in, input, 32: write data.
REQ-006 Port write_mask, input, 4: per-byte write mask, active-low; bit n = 0 writes byte n.
REQ-007 Port data_out, output, 32: registered read data.
REQ-008 Port bus_enable, input, 1: bus access strobe, held by the initiator across multiple raw_clk cycles.
REQ-009 Port write_enable, input, 1: qualifies the access as a write.
REQ-010 Port irq, output, 1: level interrupt, equal to STATUS.match AND CTRL.irq_en.

Function
REQ-011 The register map SHALL be:
- 0x0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 0x4 COUNT: 32-bit, read/write.
- 0x8 COMPARE: 32-bit, read/write.
- 0xC STATUS: bit0 match; writing 1 clears it and writing 0 has no effect.
REQ-012 data_out SHALL present the selected register one raw_clk after bus_enable is high, and SHALL update every cycle while bus_enable is high.
REQ-013 data_out SHALL hold its last value while bus_enable is low.
REQ-014 A write SHALL commit exactly once per access, on the first raw_clk edge where bus_enable AND write_enable is high and was low on the previous cycle.
REQ-015 Only bytes whose write_mask bit is 0 SHALL be modified; a mask of 4'b1111 SHALL write nothing.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 while CTRL.enable=1 and SHALL emit a one-cycle tick on wrap.
REQ-017 The prescaler SHALL clear to 0 while CTRL.enable=0.
REQ-018 The state machine SHALL have states IDLE and RUN.
REQ-019 IDLE->RUN when CTRL.enable=1; RUN->IDLE when CTRL.enable=0.
REQ-020 In RUN, each tick SHALL increment COUNT by 1, modulo 2^32; 0xFFFFFFFF wraps to 0 without setting match.
REQ-021 On a tick where COUNT==COMPARE, the block SHALL set STATUS.match and then:
- auto_reload=1: load COUNT with 0 instead of incrementing;
- auto_reload=0: clear CTRL.enable and return to IDLE, with COUNT holding its value.
REQ-022 A bus write to COUNT in the same cycle as a tick SHALL take priority; the tick is discarded.
REQ-023 When a match sets STATUS.match in the same cycle as a write-1-to-clear, set SHALL win.
REQ-024 A CTRL write that clears enable in the same cycle as a match SHALL leave enable=0, and match SHALL still set.

Reset
REQ-025 On reset_n low, the block SHALL clear CTRL, COUNT, COMPARE, STATUS, the prescaler, data_out and the write edge detector to 0, and return to IDLE.
REQ-026 irq SHALL be 0 during reset.
REQ-027 A reset asserted mid-access SHALL discard that write; after release, the write edge detector SHALL require bus_enable to be seen low before the next commit.

Configuration
REQ-028 With TIMER_PWM_EN defined, the block SHALL add output pwm_out (1 bit, reset 0), registered, high while RUN and COUNT < COMPARE and low otherwise.
REQ-029 Without TIMER_PWM_EN, the block SHALL have no pwm_out port or logic, and all other behaviour SHALL be identical.

Structure
REQ-030 Package bus_timer_pkg SHALL hold:
- the register offsets (REG_CTRL, REG_COUNT, REG_COMPARE, REG_STATUS);
- the CTRL and STATUS bit positions;
- the state encoding constants.
REQ-031 The prescaler SHALL be a sub-module timer_prescaler with ports raw_clk, reset_n, enable and tick.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Write COMPARE=5, CTRL=0x5 with PRESCALE=2 -> match after 6 ticks (12 cycles); irq=1; CTRL reads 0x4; COUNT reads 5.
- auto_reload=1, COMPARE=3 -> COUNT sequence 0,1,2,3,0,1; match set at the first 3->0 transition.
- Write COUNT=0x11223344 with write_mask=4'b1101 over prior 0 -> COUNT reads 0x00003300.
- Hold bus_enable+write_enable for 4 cycles with STATUS write 1 while match=1 -> cleared once; a new match in the clear cycle leaves match=1.
- Assert reset_n low mid-count (COUNT=7) -> all registers read 0; irq=0; no further ticks until enable is rewritten.
- With TIMER_PWM_EN, COMPARE=4, auto_reload=1 -> pwm_out high for COUNT 0..3 and low at 4, repeating.

Source files
------------

// File: rtl/bus_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_timer_pkg : register offsets, bit positions and FSM encoding     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bus_timer_pkg;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_COUNT   = 4'h4;
    localparam logic [3:0] REG_COMPARE = 4'h8;
    localparam logic [3:0] REG_STATUS  = 4'hC;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_MATCH     = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // write_mask is active-low: a 0 in bit n replaces byte n
    function automatic logic [31:0] apply_byte_mask(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  mask_n
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (!mask_n[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_timer_if : register bus between an initiator and bus_timer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bus_timer_if;
    logic [3:0]  address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic [31:0] data_out;
    logic        bus_enable;
    logic        write_enable;

    modport master (
        output address, data_in, write_mask, bus_enable, write_enable,
        input  data_out
    );

    modport slave (
        input  address, data_in, write_mask, bus_enable, write_enable,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_prescaler : divides raw_clk into a one-cycle tick every        |
// | PRESCALE cycles while enabled; held at phase 0 otherwise. Rev 1.0    |
// +----------------------------------------------------------------------+
module timer_prescaler #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic raw_clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] c_last = 16'(PRESCALE - 1);

    logic [15:0] r_phase;

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (!enable || (r_phase == c_last)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 16'd1;
        end
    end

    assign tick = enable && (r_phase == c_last);

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_timer : memory-mapped 32-bit count/compare timer, level irq.     |
// | Define TIMER_PWM_EN to add a registered pwm_out output.  Rev 1.0     |
// +----------------------------------------------------------------------+
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 12
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    bus_timer_if.slave  bus,
`ifdef TIMER_PWM_EN
    output logic        pwm_out,
`endif
    output logic        irq
);

    logic [2:0]  r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;
    logic [0:0]  r_state;
    logic        r_wr_prev;
    logic        r_armed;
    logic [31:0] r_data_out;

    logic [0:0]  w_state_nxt;
    logic [3:0]  w_off;
    logic        w_wr_req, w_commit;
    logic        w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
    logic        w_running, w_pre_en, w_tick, w_count_tick, w_hit, w_stop;
    logic [2:0]  w_ctrl_nxt;
    logic [31:0] w_count_nxt, w_compare_nxt, w_rdata;
    logic        w_match_nxt;
    logic        w_unused;

    assign w_off    = {bus.address[3:2], 2'b00};
    assign w_unused = ^bus.address[1:0];

    // r_armed stays low after reset until bus_enable is seen low, so an
    // access that straddles reset can never commit on release
    assign w_wr_req     = bus.bus_enable & bus.write_enable;
    assign w_commit     = w_wr_req & ~r_wr_prev & r_armed;
    assign w_wr_ctrl    = w_commit && (w_off == REG_CTRL);
    assign w_wr_count   = w_commit && (w_off == REG_COUNT);
    assign w_wr_compare = w_commit && (w_off == REG_COMPARE);
    assign w_wr_status  = w_commit && (w_off == REG_STATUS);

    assign w_pre_en = w_running & r_ctrl[CTRL_ENABLE];

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .raw_clk (raw_clk),
        .reset_n (reset_n),
        .enable  (w_pre_en),
        .tick    (w_tick)
    );

    // a COUNT write in the tick cycle swallows the tick entirely
    assign w_count_tick = w_tick & w_running & ~w_wr_count;
    assign w_hit        = w_count_tick && (r_count == r_compare);
    assign w_stop       = w_hit & ~r_ctrl[CTRL_AUTO_RELOAD];

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_ctrl[CTRL_ENABLE]) w_state_nxt = ST_RUN;
            ST_RUN:  if (!r_ctrl[CTRL_ENABLE] || w_stop) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_running = (r_state == ST_RUN);
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_wr_ctrl && !bus.write_mask[0]) w_ctrl_nxt = bus.data_in[2:0];
        if (w_stop) w_ctrl_nxt[CTRL_ENABLE] = 1'b0;

        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = apply_byte_mask(r_count, bus.data_in, bus.write_mask);
        end else if (w_count_tick) begin
            if (w_hit) w_count_nxt = r_ctrl[CTRL_AUTO_RELOAD] ? 32'd0 : r_count;
            else       w_count_nxt = r_count + 32'd1;
        end

        w_compare_nxt = r_compare;
        if (w_wr_compare) w_compare_nxt = apply_byte_mask(r_compare, bus.data_in, bus.write_mask);

        // set is applied after clear so a simultaneous match wins
        w_match_nxt = r_match;
        if (w_wr_status && !bus.write_mask[0] && bus.data_in[STATUS_MATCH]) w_match_nxt = 1'b0;
        if (w_hit) w_match_nxt = 1'b1;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL:    w_rdata[2:0]         = r_ctrl;
            REG_COUNT:   w_rdata              = r_count;
            REG_COMPARE: w_rdata              = r_compare;
            REG_STATUS:  w_rdata[STATUS_MATCH] = r_match;
            default:     w_rdata              = '0;
        endcase
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_wr_prev  <= 1'b0;
            r_armed    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_count   <= w_count_nxt;
            r_compare <= w_compare_nxt;
            r_match   <= w_match_nxt;
            r_wr_prev <= w_wr_req;
            if (!bus.bus_enable) r_armed <= 1'b1;
            if (bus.bus_enable) r_data_out <= w_rdata;
        end
    end

    assign bus.data_out = r_data_out;
    assign irq          = r_match & r_ctrl[CTRL_IRQ_EN];

`ifdef TIMER_PWM_EN
    logic r_pwm;

    // built from next-state values so pwm_out lines up with COUNT
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) r_pwm <= 1'b0;
        else          r_pwm <= (w_state_nxt == ST_RUN) && (w_count_nxt < w_compare_nxt);
    end

    assign pwm_out = r_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_timer : randomized + directed bench for bus_timer against a   |
// | register-level reference model. Rev 1.0                              |
// +----------------------------------------------------------------------+
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam int unsigned P = 2;

    logic raw_clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq;
`ifdef TIMER_PWM_EN
    logic pwm_out;
`endif

    bus_timer_if bus ();

    bus_timer #(.PRESCALE(P)) dut (
        .raw_clk (raw_clk),
        .reset_n (reset_n),
        .bus     (bus),
`ifdef TIMER_PWM_EN
        .pwm_out (pwm_out),
`endif
        .irq     (irq)
    );

    always #5 raw_clk = ~raw_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // reference model: m_reg[word] = CTRL, COUNT, COMPARE, STATUS
    logic [31:0] m_reg [4];
    int          m_phase;
    bit          m_run, m_prev, m_armed, m_pwm;
    logic [31:0] m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (m[b] == 1'b0) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_reg[k] = '0;
        m_phase = 0; m_run = 0; m_prev = 0; m_armed = 0; m_pwm = 0; m_dout = '0;
    endtask

    task automatic model_step();
        logic [31:0] old [4];
        int  w;
        bit  commit, tick, en, auto_r, stop;
        old    = m_reg;
        w      = int'(bus.address[3:2]);
        commit = bus.bus_enable && bus.write_enable && !m_prev && m_armed;
        en     = old[0][0];
        auto_r = old[0][1];
        stop   = 0;
        if (bus.bus_enable) m_dout = old[w];
        tick    = m_run && en && (m_phase == int'(P) - 1);
        m_phase = (m_run && en) ? (m_phase + 1) % int'(P) : 0;
        if (commit) begin
            case (w)
                0:       m_reg[0] = bmask(old[0], bus.data_in, bus.write_mask) & 32'h7;
                1, 2:    m_reg[w] = bmask(old[w], bus.data_in, bus.write_mask);
                default: if (!bus.write_mask[0] && bus.data_in[0]) m_reg[3] = '0;
            endcase
        end
        if (tick && !(commit && w == 1)) begin
            if (old[1] == old[2]) begin
                m_reg[3] = 32'd1;
                if (auto_r) m_reg[1] = '0;
                else begin m_reg[0][0] = 1'b0; stop = 1; end
            end else begin
                m_reg[1] = old[1] + 32'd1;
            end
        end
        m_run   = m_run ? (en && !stop) : en;
        m_prev  = bus.bus_enable && bus.write_enable;
        m_armed = m_armed || !bus.bus_enable;
        m_pwm   = m_run && (m_reg[1] < m_reg[2]);
    endtask

    always @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge raw_clk) begin
        if (chk_on) begin
            check("data_out", bus.data_out, m_dout);
            check("irq", 32'(irq), 32'(m_reg[3][0] & m_reg[0][2]));
`ifdef TIMER_PWM_EN
            check("pwm_out", 32'(pwm_out), 32'(m_pwm));
`endif
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m, input int hold);
        @(negedge raw_clk);
        bus.address = a; bus.data_in = d; bus.write_mask = m;
        bus.write_enable = 1'b1; bus.bus_enable = 1'b1;
        repeat (hold) @(negedge raw_clk);
        bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
        @(negedge raw_clk);
        bus.address = a; bus.write_enable = 1'b0; bus.bus_enable = 1'b1;
        @(negedge raw_clk);
        v = bus.data_out;
        bus.bus_enable = 1'b0;
    endtask

    task automatic timeout(input string name);
        n_cmp++; n_bad++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] seq [6];
        logic [31:0] exp_seq [6];
        int n, nv;
        bit found;
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        model_reset();
        bus.address = '0; bus.data_in = '0; bus.write_mask = 4'hF;
        bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
        #7 chk_on = 1'b1;
        repeat (3) @(negedge raw_clk);
        reset_n = 1'b1;

        // reset state
        check("reset irq", 32'(irq), 32'd0);
        bus_read(REG_CTRL, v);    check("reset CTRL", v, 32'd0);
        bus_read(REG_COUNT, v);   check("reset COUNT", v, 32'd0);
        bus_read(REG_COMPARE, v); check("reset COMPARE", v, 32'd0);
        bus_read(REG_STATUS, v);  check("reset STATUS", v, 32'd0);

        // one-shot match: 6 ticks of 2 cycles after the IDLE->RUN cycle
        bus_write(REG_COMPARE, 32'd5, 4'h0, 1);
        bus_write(REG_CTRL, 32'h5, 4'h0, 1);
        n = 0; found = 0;
        for (int c = 1; c <= 60 && !found; c++) begin
            @(negedge raw_clk);
            if (irq) begin found = 1; n = c; end
        end
        if (!found) timeout("oneshot irq");
        else check("oneshot latency", 32'(n), 32'd13);
        bus_read(REG_CTRL, v);  check("oneshot CTRL", v, 32'h4);
        bus_read(REG_COUNT, v); check("oneshot COUNT", v, 32'd5);
        bus_write(REG_STATUS, 32'd1, 4'h0, 1);
        check("w1c irq", 32'(irq), 32'd0);

        // auto-reload sequence
        bus_write(REG_COUNT, 32'd0, 4'h0, 1);
        bus_write(REG_COMPARE, 32'd3, 4'h0, 1);
        bus_write(REG_CTRL, 32'h3, 4'h0, 1);
        @(negedge raw_clk);
        bus.address = REG_COUNT; bus.bus_enable = 1'b1;
        nv = 0;
        for (int c = 0; c < 60 && nv < 6; c++) begin
            @(negedge raw_clk);
            if (nv == 0 || bus.data_out != seq[nv-1]) begin seq[nv] = bus.data_out; nv++; end
        end
        bus.bus_enable = 1'b0;
        if (nv < 6) timeout("reload sequence");
        else for (int i = 0; i < 6; i++) check("reload seq", seq[i], exp_seq[i]);
        bus_read(REG_STATUS, v); check("reload STATUS", v, 32'd1);
        bus_write(REG_CTRL, 32'h0, 4'h0, 1);
        bus_write(REG_STATUS, 32'd1, 4'h0, 1);

        // byte masks
        bus_write(REG_COUNT, 32'd0, 4'h0, 1);
        bus_write(REG_COUNT, 32'h11223344, 4'b1101, 1);
        bus_read(REG_COUNT, v); check("mask 1101", v, 32'h00003300);
        bus_write(REG_COMPARE, 32'hFFFFFFFF, 4'b1111, 1);
        bus_read(REG_COMPARE, v); check("mask 1111", v, 32'd3);

        // held w1c while matches keep arriving
        bus_write(REG_COMPARE, 32'd0, 4'h0, 1);
        bus_write(REG_COUNT, 32'd0, 4'h0, 1);
        bus_write(REG_CTRL, 32'h7, 4'h0, 1);
        repeat (5) @(negedge raw_clk);
        bus_write(REG_STATUS, 32'd1, 4'h0, 4);
        check("held w1c irq A", 32'(irq), 32'd1);
        bus_read(REG_STATUS, v); check("held w1c STATUS A", v, 32'd1);
        @(negedge raw_clk);
        bus_write(REG_STATUS, 32'd1, 4'h0, 4);
        check("held w1c irq B", 32'(irq), 32'd1);
        bus_write(REG_CTRL, 32'h0, 4'h0, 1);
        bus_write(REG_STATUS, 32'd1, 4'h0, 1);

        // reset mid-count, and a write held across reset
        bus_write(REG_COMPARE, 32'd100, 4'h0, 1);
        bus_write(REG_COUNT, 32'd0, 4'h0, 1);
        bus_write(REG_CTRL, 32'h5, 4'h0, 1);
        @(negedge raw_clk);
        bus.address = REG_COUNT; bus.bus_enable = 1'b1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge raw_clk);
            if (bus.data_out == 32'd7) found = 1;
        end
        if (!found) timeout("count to 7");
        #2 reset_n = 1'b0;
        @(negedge raw_clk);
        check("in reset data_out", bus.data_out, 32'd0);
        check("in reset irq", 32'(irq), 32'd0);
        bus.address = REG_CTRL; bus.data_in = 32'h1; bus.write_mask = 4'h0;
        bus.write_enable = 1'b1; bus.bus_enable = 1'b1;
        repeat (2) @(negedge raw_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge raw_clk);
        bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
        bus_read(REG_CTRL, v);    check("post reset CTRL", v, 32'd0);
        bus_read(REG_COMPARE, v); check("post reset COMPARE", v, 32'd0);
        bus_read(REG_STATUS, v);  check("post reset STATUS", v, 32'd0);
        repeat (20) @(negedge raw_clk);
        bus_read(REG_COUNT, v);   check("post reset COUNT", v, 32'd0);

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            logic [3:0]  m;
            repeat ($urandom_range(0, 2)) @(negedge raw_clk);
            a = 4'($urandom_range(0, 15));
            case (a[3:2])
                2'd0:    d = 32'($urandom_range(0, 7));
                2'd3:    d = 32'($urandom_range(0, 1));
                default: d = 32'($urandom_range(0, 12));
            endcase
            if ($urandom_range(0, 15) == 0) d = 32'hFFFFFFFE;
            if ($urandom_range(0, 7) == 0)  d = $urandom;
            m = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1)) bus_write(a, d, m, int'($urandom_range(1, 4)));
            else                      bus_read(a, v);
        end

        repeat (4) @(negedge raw_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
